// File: rtl/decoder_pkg.sv
// Shared word type used by the CSR/decoder side of the design.
package decoder_pkg;
  typedef logic [31:0] word;
endpackage

// File: rtl/uart_pkg.sv
// Common types and constants for the UART receive path.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;

  localparam int UartDataBits = 8;
  localparam logic ParityOdd = 1'b0;  // even parity when UART_RX_PARITY_EN is set
endpackage

// File: rtl/uart_rx_fifo.sv
// Small elastic output buffer for received bytes: DEPTH entries, first-word-fall-through.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UartDataBits
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] last;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A simultaneous pop frees the head slot, so a push into a full buffer is accepted.
  assign push_ok = push && (!full || pop);

  // When empty the output holds the most recently popped byte.
  assign dout = empty ? last : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // NOTE: storage has no reset; an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (8E1 with UART_RX_PARITY_EN) frames on rx, LSB first,
// bytes delivered through a DEPTH-entry valid/ready buffer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] prescaler,
  input  logic        rx,
  output logic [7:0]  data,
  output logic        valid,
  input  logic        ready,
  output logic        frame_err,
  output logic        overrun,
  output logic        parity_err
);
  uart_rx_state_t          state;
  decoder_pkg::word        cnt;
  logic [2:0]              bit_idx;
  logic [UartDataBits-1:0] shift;
  logic                    rx_meta;
  logic                    rx_s;
  logic                    rx_prev;
  logic                    sample;
  logic                    stop_hit;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;

  assign sample   = (cnt == '0);
  assign stop_hit = (state == STOP) && sample;
  assign push     = stop_hit && rx_s;
  assign pop      = valid && ready;
  assign valid    = !empty;

  // NOTE: pulses are plain continuous assigns from registered state, so no latch can form.
  assign frame_err = stop_hit && !rx_s;
  assign overrun   = push && full && !pop;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign parity_err = stop_hit && par_bad;
`else
  assign parity_err = 1'b0;
`endif

  // NOTE: all state below uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;

      case (state)
        IDLE: begin
          if (!rx_s && rx_prev) begin
            // With a one-cycle bit the detecting sample already is the start-bit sample.
            if (prescaler == '0) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              cnt   <= prescaler >> 1;
              state <= START;
            end
          end
        end
        START: begin
          if (sample) begin
            if (!rx_s) begin
              cnt     <= prescaler;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        DATA: begin
          if (sample) begin
            shift[bit_idx] <= rx_s;
            cnt            <= prescaler;
            if (bit_idx == 3'(UartDataBits - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample) begin
            par_bad <= ^shift ^ rx_s ^ ParityOdd;
            cnt     <= prescaler;
            state   <= STOP;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
`endif
        STOP: begin
          if (sample) state <= IDLE;
          else        cnt   <= cnt - 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(UartDataBits)
  ) u_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push   (push),
    .pop    (pop),
    .din    (shift),
    .dout   (data),
    .full   (full),
    .empty  (empty)
  );
endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx; the bench drives the serial line itself.
module tb_uart_rx;
`ifdef UART_RX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] prescaler;
  logic        rx;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        frame_err;
  logic        overrun;
  logic        parity_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          fe_cnt  = 0;
  int          ov_cnt  = 0;
  int          pe_cnt  = 0;
  logic [7:0]  got[$];

  always #5 clk_i = ~clk_i;

  uart_rx #(.DEPTH(4)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .prescaler (prescaler),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  // Popped bytes and error pulses, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (valid && ready) got.push_back(data);
      if (frame_err)  fe_cnt++;
      if (overrun)    ov_cnt++;
      if (parity_err) pe_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic put_bit(input logic b);
    rx = b;
    repeat (int'(prescaler) + 1) @(negedge clk_i);
  endtask

  // par_flip inverts the parity bit (only sent when parity is enabled).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    put_bit(^b ^ par_flip);
`endif
    put_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic clear_obs();
    got.delete();
    fe_cnt = 0;
    ov_cnt = 0;
    pe_cnt = 0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int i;
    i = 0;
    while (got.size() < n && i < budget) begin
      @(negedge clk_i);
      i++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1_bytes [4];
    t1_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    rx        = 1'b1;
    ready     = 1'b1;
    prescaler = 32'd0;
    reset_i   = 1'b1;
    repeat (3) @(negedge clk_i);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    check("reset_pulses", {29'd0, frame_err, overrun, parity_err}, 32'd0);
    reset_i = 1'b0;
    idle(4);

    // 1: back-to-back frames at one clock per bit
    clear_obs();
    for (int i = 0; i < 4; i++) send_frame(t1_bytes[i], 1'b1, 1'b0);
    idle(4);
    wait_bytes(4, 200);
    check("t1_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check($sformatf("t1_byte%0d", i), 32'(got[i]), 32'(t1_bytes[i]));
    check("t1_errs", fe_cnt + ov_cnt + pe_cnt, 0);
    check("t1_empty", 32'(valid), 32'd0);
    check("t1_hold_last", 32'(data), 32'hEF);

    // 2: exact latency from start edge to valid at prescaler=3
    prescaler = 32'd3;
    idle(8);
    clear_obs();
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        repeat (4 * FrameBits) @(posedge clk_i);
        @(negedge clk_i);
        check("t2_not_yet", 32'(valid), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("t2_valid", 32'(valid), 32'd1);
        check("t2_data", 32'(data), 32'h55);
      end
    join
    idle(8);
    check("t2_count", got.size(), 1);
    check("t2_errs", fe_cnt + ov_cnt + pe_cnt, 0);

    // 3: overrun on the fifth byte with the consumer stalled
    ready = 1'b0;
    clear_obs();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    idle(4);
    check("t3_no_ovr_yet", ov_cnt, 0);
    check("t3_valid", 32'(valid), 32'd1);
    send_frame(8'h05, 1'b1, 1'b0);
    idle(4);
    check("t3_ovr", ov_cnt, 1);
    ready = 1'b1;
    wait_bytes(4, 50);
    idle(4);
    check("t3_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check($sformatf("t3_byte%0d", i), 32'(got[i]), i + 1);
    check("t3_drained", 32'(valid), 32'd0);

    // 4: low stop bit drops the byte, next frame is clean
    clear_obs();
    send_frame(8'hA5, 1'b0, 1'b0);
    idle(8);
    check("t4_frame_err", fe_cnt, 1);
    check("t4_no_byte", got.size(), 0);
    check("t4_valid", 32'(valid), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(8);
    check("t4_count", got.size(), 1);
    if (got.size() > 0) check("t4_byte", 32'(got[0]), 32'h3C);
    check("t4_fe_total", fe_cnt, 1);

    // 5: one-clock glitch is rejected at the start-bit sample
    prescaler = 32'd7;
    idle(4);
    clear_obs();
    rx = 1'b0;
    @(negedge clk_i);
    idle(40);
    check("t5_no_byte", got.size(), 0);
    check("t5_no_pulse", fe_cnt + ov_cnt + pe_cnt, 0);
    check("t5_valid", 32'(valid), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(12);
    check("t5_after_count", got.size(), 1);
    if (got.size() > 0) check("t5_after_byte", 32'(got[0]), 32'h81);

    // 6: reset in the middle of a data bit sequence
    prescaler = 32'd3;
    idle(4);
    clear_obs();
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
      end
    join
    idle(8);
    check("t6_valid", 32'(valid), 32'd0);
    check("t6_data", 32'(data), 32'd0);
    check("t6_nothing", got.size() + fe_cnt + ov_cnt + pe_cnt, 0);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(8);
    check("t6_count", got.size(), 1);
    if (got.size() > 0) check("t6_byte", 32'(got[0]), 32'h12);

`ifdef UART_RX_PARITY_EN
    // parity mismatch still delivers the byte
    clear_obs();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(8);
    check("par_err", pe_cnt, 1);
    check("par_count", got.size(), 1);
    if (got.size() > 0) check("par_byte", 32'(got[0]), 32'h07);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
